// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing one classic WISHBONE I/O slave bus between NUM_M masters.
// Optional forced-termination timeout is enabled by defining IO_BUS_ARBITER_TIMEOUT_EN.
module io_bus_arbiter #(
   parameter int NUM_M   = 2,
   parameter int ADR_W   = 8,
   parameter int DAT_W   = 8,
   parameter int TIMEOUT = 15
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic [NUM_M*ADR_W-1:0] m_adr_i,
   input  logic [NUM_M*DAT_W-1:0] m_dat_i,
   input  logic [NUM_M-1:0]       m_stb_i,
   input  logic [NUM_M-1:0]       m_we_i,
   output logic [DAT_W-1:0]       m_dat_o,
   output logic [NUM_M-1:0]       m_ack_o,
   output logic [ADR_W-1:0]       s_adr_o,
   output logic [DAT_W-1:0]       s_dat_o,
   input  logic [DAT_W-1:0]       s_dat_i,
   output logic                   s_stb_o,
   output logic                   s_we_o,
   input  logic                   s_ack_i,
   output logic [NUM_M-1:0]       gnt_o,
   output logic                   busy_o,
   output logic                   to_err_o
);

   localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t state, next_state;

   logic [IDX_W-1:0] gnt_idx;
   logic [IDX_W-1:0] last_gnt;
   logic [IDX_W-1:0] win_idx;
   logic [IDX_W-1:0] cand;
   logic             win_found;
   logic             any_req;
   logic             grant_end;
   logic             timeout_hit;

   logic [ADR_W-1:0] adr_arr [NUM_M];
   logic [DAT_W-1:0] dat_arr [NUM_M];

   for (genvar k = 0; k < NUM_M; k++) begin : g_unpack
      assign adr_arr[k] = m_adr_i[k*ADR_W +: ADR_W];
      assign dat_arr[k] = m_dat_i[k*DAT_W +: DAT_W];
   end

   assign any_req = |m_stb_i;
   assign busy_o  = (state == GRANT);

   // Search upward from the master after the last one served, wrapping at NUM_M.
   always_comb begin
      win_idx   = '0;
      win_found = 1'b0;
      cand      = last_gnt;
      for (int i = 0; i < NUM_M; i++) begin
         cand = (cand == IDX_W'(NUM_M - 1)) ? '0 : cand + 1'b1;
         if (!win_found && m_stb_i[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

`ifdef IO_BUS_ARBITER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] to_cnt;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         to_cnt <= '0;
      end else if (state == IDLE) begin
         to_cnt <= '0;
      end else if (!s_ack_i) begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   assign timeout_hit = (state == GRANT) && !s_ack_i && (to_cnt == CNT_W'(TIMEOUT - 1));
`else
   logic unused_timeout;

   assign unused_timeout = (TIMEOUT == 0);
   assign timeout_hit    = 1'b0;
`endif

   assign to_err_o  = timeout_hit;
   assign grant_end = s_ack_i || !m_stb_i[gnt_idx] || timeout_hit;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (any_req) next_state = GRANT;
         GRANT:   if (grant_end) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // An aborted grant still advances last_gnt, so a dropping master cannot block rotation.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         gnt_idx  <= '0;
         gnt_o    <= '0;
         last_gnt <= IDX_W'(NUM_M - 1);
      end else if (state == IDLE && any_req) begin
         gnt_idx <= win_idx;
         gnt_o   <= {{(NUM_M-1){1'b0}}, 1'b1} << win_idx;
      end else if (state == GRANT && grant_end) begin
         last_gnt <= gnt_idx;
         gnt_o    <= '0;
      end
   end

   always_comb begin
      s_stb_o = 1'b0;
      s_we_o  = 1'b0;
      s_adr_o = '0;
      s_dat_o = '0;
      m_dat_o = '0;
      m_ack_o = '0;
      if (state == GRANT) begin
         s_adr_o          = adr_arr[gnt_idx];
         s_dat_o          = dat_arr[gnt_idx];
         s_we_o           = m_we_i[gnt_idx];
         s_stb_o          = m_stb_i[gnt_idx] && !timeout_hit;
         m_ack_o[gnt_idx] = s_ack_i || timeout_hit;
         m_dat_o          = (timeout_hit && !s_ack_i) ? '1 : s_dat_i;
      end
   end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed, table-driven bench for io_bus_arbiter with two masters and 8-bit buses.
// Timeout checks follow IO_BUS_ARBITER_TIMEOUT_EN.
module tb_io_bus_arbiter;

   typedef struct packed {
      logic [1:0] stb;
      logic [1:0] we;
      logic [7:0] adr0;
      logic [7:0] adr1;
      logic [7:0] dat0;
      logic [7:0] dat1;
      logic       sack;
      logic [7:0] sdat;
   } in_t;

   typedef struct packed {
      logic       s_stb;
      logic       s_we;
      logic [7:0] s_adr;
      logic [7:0] s_dat;
      logic [1:0] m_ack;
      logic [7:0] m_dat;
      logic [1:0] gnt;
      logic       busy;
      logic       to_err;
   } exp_t;

   typedef struct packed {
      in_t  stim;
      exp_t ex;
   } vec_t;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic [15:0] m_adr;
   logic [15:0] m_dat;
   logic [1:0]  m_stb;
   logic [1:0]  m_we;
   logic [7:0]  m_dat_o;
   logic [1:0]  m_ack_o;
   logic [7:0]  s_adr_o;
   logic [7:0]  s_dat_o;
   logic [7:0]  s_dat;
   logic        s_stb_o;
   logic        s_we_o;
   logic        s_ack;
   logic [1:0]  gnt_o;
   logic        busy_o;
   logic        to_err_o;

   int n_vec = 0;
   int n_mis = 0;

   vec_t vecs[$];

   io_bus_arbiter dut (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .m_adr_i  (m_adr),
      .m_dat_i  (m_dat),
      .m_stb_i  (m_stb),
      .m_we_i   (m_we),
      .m_dat_o  (m_dat_o),
      .m_ack_o  (m_ack_o),
      .s_adr_o  (s_adr_o),
      .s_dat_o  (s_dat_o),
      .s_dat_i  (s_dat),
      .s_stb_o  (s_stb_o),
      .s_we_o   (s_we_o),
      .s_ack_i  (s_ack),
      .gnt_o    (gnt_o),
      .busy_o   (busy_o),
      .to_err_o (to_err_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic in_t mi(input logic [1:0] stb, input logic [1:0] we,
                              input logic [7:0] a0, input logic [7:0] a1,
                              input logic [7:0] d0, input logic [7:0] d1,
                              input logic sack, input logic [7:0] sdat);
      return {stb, we, a0, a1, d0, d1, sack, sdat};
   endfunction

   function automatic exp_t me(input logic stb, input logic we, input logic [7:0] adr,
                               input logic [7:0] dat, input logic [1:0] ack,
                               input logic [7:0] rdat, input logic [1:0] gnt,
                               input logic busy, input logic to_err);
      return {stb, we, adr, dat, ack, rdat, gnt, busy, to_err};
   endfunction

   function automatic exp_t idle_e();
      return me(1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 8'h00, 2'b00, 1'b0, 1'b0);
   endfunction

   function automatic void add(input in_t s, input exp_t e);
      vec_t v;
      v.stim = s;
      v.ex   = e;
      vecs.push_back(v);
   endfunction

   task automatic applyStimulus(input in_t s);
      m_stb = s.stb;
      m_we  = s.we;
      m_adr = {s.adr1, s.adr0};
      m_dat = {s.dat1, s.dat0};
      s_ack = s.sack;
      s_dat = s.sdat;
   endtask

   task automatic checkOutput(input string tag, input exp_t ex);
      exp_t act;
      act = {s_stb_o, s_we_o, s_adr_o, s_dat_o, m_ack_o, m_dat_o, gnt_o, busy_o, to_err_o};
      n_vec++;
      if (act !== ex) begin
         n_mis++;
         $display("[TB] FAIL %s: got stb=%b we=%b adr=%h dat=%h ack=%b rdat=%h gnt=%b busy=%b to=%b, expected stb=%b we=%b adr=%h dat=%h ack=%b rdat=%h gnt=%b busy=%b to=%b",
                  tag, act.s_stb, act.s_we, act.s_adr, act.s_dat, act.m_ack, act.m_dat,
                  act.gnt, act.busy, act.to_err, ex.s_stb, ex.s_we, ex.s_adr, ex.s_dat,
                  ex.m_ack, ex.m_dat, ex.gnt, ex.busy, ex.to_err);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk_i);
      #1;
   endtask

   // Inputs change 1 after the rising edge; outputs are sampled 1 later, well clear of the edge.
   initial begin
      // Contention from reset: strict 0,1,0,1 with one idle cycle between transactions.
      add(mi(2'b11, 2'b00, 8'h01, 8'h02, 8'h11, 8'h22, 1'b0, 8'h00), idle_e());
      add(mi(2'b11, 2'b00, 8'h01, 8'h02, 8'h11, 8'h22, 1'b1, 8'hA0),
          me(1'b1, 1'b0, 8'h01, 8'h11, 2'b01, 8'hA0, 2'b01, 1'b1, 1'b0));
      add(mi(2'b11, 2'b00, 8'h01, 8'h02, 8'h11, 8'h22, 1'b0, 8'h00), idle_e());
      add(mi(2'b11, 2'b00, 8'h01, 8'h02, 8'h11, 8'h22, 1'b1, 8'hA1),
          me(1'b1, 1'b0, 8'h02, 8'h22, 2'b10, 8'hA1, 2'b10, 1'b1, 1'b0));
      add(mi(2'b11, 2'b00, 8'h01, 8'h02, 8'h11, 8'h22, 1'b0, 8'h00), idle_e());
      add(mi(2'b11, 2'b00, 8'h01, 8'h02, 8'h11, 8'h22, 1'b1, 8'hA2),
          me(1'b1, 1'b0, 8'h01, 8'h11, 2'b01, 8'hA2, 2'b01, 1'b1, 1'b0));
      add(mi(2'b11, 2'b00, 8'h01, 8'h02, 8'h11, 8'h22, 1'b0, 8'h00), idle_e());
      add(mi(2'b11, 2'b00, 8'h01, 8'h02, 8'h11, 8'h22, 1'b1, 8'hA3),
          me(1'b1, 1'b0, 8'h02, 8'h22, 2'b10, 8'hA3, 2'b10, 1'b1, 1'b0));
      add(mi(2'b00, 2'b00, 8'h01, 8'h02, 8'h11, 8'h22, 1'b0, 8'h00), idle_e());
      // Single read by master 0, slave acks on the third GRANT cycle; then a stray ack in IDLE.
      add(mi(2'b01, 2'b00, 8'h3A, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00), idle_e());
      add(mi(2'b01, 2'b00, 8'h3A, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00),
          me(1'b1, 1'b0, 8'h3A, 8'h00, 2'b00, 8'h00, 2'b01, 1'b1, 1'b0));
      add(mi(2'b01, 2'b00, 8'h3A, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00),
          me(1'b1, 1'b0, 8'h3A, 8'h00, 2'b00, 8'h00, 2'b01, 1'b1, 1'b0));
      add(mi(2'b01, 2'b00, 8'h3A, 8'h00, 8'h00, 8'h00, 1'b1, 8'h5C),
          me(1'b1, 1'b0, 8'h3A, 8'h00, 2'b01, 8'h5C, 2'b01, 1'b1, 1'b0));
      add(mi(2'b00, 2'b00, 8'h3A, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00), idle_e());
      add(mi(2'b00, 2'b00, 8'h3A, 8'h00, 8'h00, 8'h00, 1'b1, 8'h77), idle_e());
      // Master 1 writes 0xA5 to 0x10.
      add(mi(2'b10, 2'b10, 8'h00, 8'h10, 8'h00, 8'hA5, 1'b0, 8'h00), idle_e());
      add(mi(2'b10, 2'b10, 8'h00, 8'h10, 8'h00, 8'hA5, 1'b1, 8'h00),
          me(1'b1, 1'b1, 8'h10, 8'hA5, 2'b10, 8'h00, 2'b10, 1'b1, 1'b0));
      add(mi(2'b00, 2'b00, 8'h00, 8'h10, 8'h00, 8'hA5, 1'b0, 8'h00), idle_e());
      // Master 0 aborts while master 1 waits; master 1 is served next.
      add(mi(2'b01, 2'b00, 8'h44, 8'h55, 8'h00, 8'h00, 1'b0, 8'h00), idle_e());
      add(mi(2'b11, 2'b00, 8'h44, 8'h55, 8'h00, 8'h00, 1'b0, 8'h00),
          me(1'b1, 1'b0, 8'h44, 8'h00, 2'b00, 8'h00, 2'b01, 1'b1, 1'b0));
      add(mi(2'b10, 2'b00, 8'h44, 8'h55, 8'h00, 8'h00, 1'b0, 8'h00),
          me(1'b0, 1'b0, 8'h44, 8'h00, 2'b00, 8'h00, 2'b01, 1'b1, 1'b0));
      add(mi(2'b10, 2'b00, 8'h44, 8'h55, 8'h00, 8'h00, 1'b0, 8'h00), idle_e());
      add(mi(2'b10, 2'b00, 8'h44, 8'h55, 8'h00, 8'h00, 1'b1, 8'h66),
          me(1'b1, 1'b0, 8'h55, 8'h00, 2'b10, 8'h66, 2'b10, 1'b1, 1'b0));
      add(mi(2'b00, 2'b00, 8'h44, 8'h55, 8'h00, 8'h00, 1'b0, 8'h00), idle_e());

      rst_n_i = 1'b0;
      applyStimulus(mi(2'b11, 2'b00, 8'h01, 8'h02, 8'h11, 8'h22, 1'b1, 8'h99));
      repeat (3) @(posedge clk_i);
      #2;
      checkOutput("reset_state", idle_e());
      #2;
      @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].stim);
         #1;
         checkOutput($sformatf("vec%0d", i), vecs[i].ex);
         nextCycle();
      end

      // Reset in the middle of a grant: master 0 is served first so last_gnt points at it.
      applyStimulus(mi(2'b01, 2'b00, 8'h3A, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00));
      #1;
      checkOutput("rst_pre_idle", idle_e());
      nextCycle();
      applyStimulus(mi(2'b01, 2'b00, 8'h3A, 8'h00, 8'h00, 8'h00, 1'b1, 8'h5C));
      #1;
      checkOutput("rst_pre_ack", me(1'b1, 1'b0, 8'h3A, 8'h00, 2'b01, 8'h5C, 2'b01, 1'b1, 1'b0));
      nextCycle();
      applyStimulus(mi(2'b01, 2'b00, 8'h3A, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00));
      #1;
      checkOutput("rst_turnaround", idle_e());
      nextCycle();
      #1;
      checkOutput("rst_mid_grant", me(1'b1, 1'b0, 8'h3A, 8'h00, 2'b00, 8'h00, 2'b01, 1'b1, 1'b0));
      #2;
      rst_n_i = 1'b0;
      #1;
      checkOutput("rst_async", idle_e());
      applyStimulus(mi(2'b11, 2'b00, 8'h3A, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00));
      nextCycle();
      rst_n_i = 1'b1;
      #1;
      checkOutput("rst_release", idle_e());
      nextCycle();
      #1;
      checkOutput("rst_first_gnt", me(1'b1, 1'b0, 8'h3A, 8'h00, 2'b00, 8'h00, 2'b01, 1'b1, 1'b0));

      // Slave never acks; the grant above is GRANT cycle 1.
`ifdef IO_BUS_ARBITER_TIMEOUT_EN
      for (int n = 2; n <= 14; n++) begin
         nextCycle();
         #1;
         checkOutput($sformatf("to_wait%0d", n),
                     me(1'b1, 1'b0, 8'h3A, 8'h00, 2'b00, 8'h00, 2'b01, 1'b1, 1'b0));
      end
      nextCycle();
      #1;
      checkOutput("to_pulse", me(1'b0, 1'b0, 8'h3A, 8'h00, 2'b01, 8'hFF, 2'b01, 1'b1, 1'b1));
      nextCycle();
      #1;
      checkOutput("to_idle", idle_e());
      applyStimulus(mi(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00));
      nextCycle();
`else
      for (int n = 2; n <= 120; n++) begin
         nextCycle();
         #1;
         checkOutput($sformatf("hold%0d", n),
                     me(1'b1, 1'b0, 8'h3A, 8'h00, 2'b00, 8'h00, 2'b01, 1'b1, 1'b0));
      end
      nextCycle();
      applyStimulus(mi(2'b00, 2'b00, 8'h3A, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00));
      #1;
      checkOutput("hold_abort", me(1'b0, 1'b0, 8'h3A, 8'h00, 2'b00, 8'h00, 2'b01, 1'b1, 1'b0));
      nextCycle();
      #1;
      checkOutput("hold_idle", idle_e());
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
